banco_registradores: RTL and testbench
======================================

# banco_registradores

Issue and write-back stage for the mini-CPU datapath. It accepts one 18-bit instruction at a time, reads source operands from a 16×16 register file, and drives them, with the opcode and immediate, to `operacoes`. It then waits for `fimop`, pulses `flag_ram`, and writes `saida` into the destination register. Instructions execute strictly one at a time, so the datapath has no hazards.

## Interface
- `WIDTH`, 16: data width of registers and ALU operands.
- `TIMEOUT`, 255: maximum cycles in WAIT_RES before the instruction is aborted (1..255).
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `instr_valid`  in  1: `instr` is valid.
- `instr_ready`  out  1: block is in IDLE and can accept an instruction.
- `instr`  in  18: `[17:15]` opcode, `[14:11]` dest, `[10:7]` src1, `[6:3]` src2, `[6:0]` imm7 (src2 and imm7 overlap by design).
- `opcode`  out  3: to ALU, registered.
- `r2`, `r3`  out  16: reg[src1] and reg[src2] to ALU, registered.
- `D1`  out  4: dest index to ALU, registered.
- `entrada`  out  7: imm7 to ALU, registered.
- `fimop`  in  1: ALU result-ready.
- `saida`  in  16: ALU result.
- `flag_ram`  out  1: one-cycle result acknowledge to ALU.
- `dbg_addr`  in  4: debug read index.
- `dbg_data`  out  16: combinational reg[dbg_addr].
- `retired`  out  16: count of written-back instructions; wraps at 0xFFFF→0.
- `erro`  out  2: sticky; bit0 = timeout, bit1 = illegal opcode.

## Operation
- Opcodes: 000 load, 001 add, 010 addi, 011 sub, 100 subi, 101 mul. 110 and 111 are illegal.
- FSM states: IDLE, WAIT_RES, ACK, WRITE.
- IDLE
  - `instr_ready` = 1.
  - On `instr_valid`, the instruction is accepted.
  - Legal opcode: register opcode, r2, r3, D1 and entrada, clear the watchdog, go to WAIT_RES.
  - Illegal opcode: set erro[1], stay in IDLE. Nothing is issued, and `retired` is unchanged.
- WAIT_RES
  - The watchdog increments each cycle.
  - `fimop`=1 → ACK.
  - Watchdog reaches TIMEOUT with `fimop`=0 → set erro[0], go to IDLE with no write.
- ACK: `flag_ram`=1 for exactly this cycle, then go to WRITE.
- WRITE
  - Write `saida` into reg[D1]; increment `retired`; go to IDLE.
  - R0 is hardwired to zero: writes with D1=0 are discarded, but `retired` still increments.
- ALU outputs hold their values from accept until the next accept; they do not change in any other state.
- Operand reads use register contents at the accept edge. Because write-back completes before the next accept, no forwarding is needed.
- `dbg_data` reads the register file asynchronously and reflects a write on the cycle after WRITE.
- `erro` is cleared only by `rst`.

## Timing
- Reset values:
  - state = IDLE, `instr_ready` = 1.
  - All registers = 0.
  - opcode, r2, r3, D1, entrada = 0.
  - `flag_ram` = 0, `retired` = 0, `erro` = 0.
- Accept at edge E0: ALU inputs are valid from E0 onward.
- If `fimop` is first sampled high at edge Ek:
  - `flag_ram` is high during cycle (Ek, Ek+1].
  - The register write happens at Ek+2.
  - `instr_ready` returns at Ek+2.
- Minimum accept-to-accept spacing is 4 cycles (`fimop` high at the first WAIT_RES edge).
- `instr_valid` while `instr_ready`=0 is ignored, not queued.
- `rst` mid-instruction aborts immediately: registers, counters and error bits are cleared and `flag_ram` drops asynchronously.
- A `fimop` pulse in IDLE, ACK or WRITE is ignored.
- Timeout takes priority over nothing: if `fimop` is sampled high on the same edge the watchdog hits TIMEOUT, `fimop` wins and the transition is to ACK.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams (load…mul);
  - instruction field bit positions;
  - FSM state encoding (2 bits).
- Sub-module `regfile_16x16`:
  - asynchronous reset;
  - two combinational read ports for src1/src2, plus the debug port (three reads total);
  - one synchronous write port with R0 write suppression.
- The FSM, watchdog, retire counter and ALU-side output registers live in the top module.

## Test plan
- Load: `instr` = {000, dest=3, imm=7'h7F}; ALU model raises `fimop` 2 cycles later with `saida`=0xFFFF → `flag_ram` is a single pulse, reg3=0xFFFF, `retired`=1.
- Add with operand read: preload R1=5, R2=0xFFFE; issue add dest=4, src1=1, src2=2 → `r2`=0x0005 and `r3`=0xFFFE at accept; `saida`=0x0003 is written to R4.
- R0 write: issue load dest=0 with `saida`=0x1234 → `dbg_data`(0)=0 and `retired` increments.
- Timeout: issue addi and never assert `fimop` → after 255 WAIT_RES cycles, `erro`=01, no register changes, `instr_ready`=1.
- Illegal opcode and backpressure: opcode 111 → `erro`[1]=1, `retired` unchanged. `instr_valid` held high during WAIT_RES → no second accept.
- Reset mid-op: assert `rst` during ACK → `flag_ram`=0 immediately, all registers 0, state IDLE. Separately, force `retired`=0xFFFF and retire one instruction → `retired`=0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-CPU datapath: opcodes, instruction field
// positions and the issue/write-back FSM encoding.
package cpu_pkg;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;

  localparam int INSTR_W  = 18;
  localparam int OP_MSB   = 17;
  localparam int OP_LSB   = 15;
  localparam int DST_MSB  = 14;
  localparam int DST_LSB  = 11;
  localparam int SRC1_MSB = 10;
  localparam int SRC1_LSB = 7;
  localparam int SRC2_MSB = 6;
  localparam int SRC2_LSB = 3;
  localparam int IMM_MSB  = 6;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RES = 2'd1,
    ST_ACK      = 2'd2,
    ST_WRITE    = 2'd3
  } state_t;

  // 110 and 111 are the only unassigned encodings.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/regfile_16x16.sv
// 16-entry register file: two operand read ports, one debug read port and a
// single synchronous write port. R0 always reads as zero.
module regfile_16x16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [3:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [3:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [3:0]       raddr_d,
  output logic [WIDTH-1:0] rdata_d
);

  logic [WIDTH-1:0] regs [16];

  // R0 is never written, so its reset value of zero is permanent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (we && (waddr != 4'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/banco_registradores.sv
// Issue and write-back stage: accepts one instruction, drives operands to the
// ALU, waits for its result (with a watchdog) and writes it back.
module banco_registradores
  import cpu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [INSTR_W-1:0]   instr,
  output logic [2:0]           opcode,
  output logic [WIDTH-1:0]     r2,
  output logic [WIDTH-1:0]     r3,
  output logic [3:0]           D1,
  output logic [6:0]           entrada,
  input  logic                 fimop,
  input  logic [WIDTH-1:0]     saida,
  output logic                 flag_ram,
  input  logic [3:0]           dbg_addr,
  output logic [WIDTH-1:0]     dbg_data,
  output logic [15:0]          retired,
  output logic [1:0]           erro,
  output state_t               dbg_state
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_valid while instr_ready is low is dropped.
  state_t           state;
  logic [7:0]       wd;
  logic [15:0]      retired_q;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  regfile_16x16 #(.WIDTH(WIDTH)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (state == ST_WRITE),
    .waddr   (D1),
    .wdata   (saida),
    .raddr_a (instr[SRC1_MSB:SRC1_LSB]),
    .rdata_a (rd_a),
    .raddr_b (instr[SRC2_MSB:SRC2_LSB]),
    .rdata_b (rd_b),
    .raddr_d (dbg_addr),
    .rdata_d (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wd        <= '0;
      opcode    <= '0;
      r2        <= '0;
      r3        <= '0;
      D1        <= '0;
      entrada   <= '0;
      flag_ram  <= 1'b0;
      retired_q <= '0;
      erro      <= '0;
    end else begin
      flag_ram <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            if (op_legal(instr[OP_MSB:OP_LSB])) begin
              opcode  <= instr[OP_MSB:OP_LSB];
              r2      <= rd_a;
              r3      <= rd_b;
              D1      <= instr[DST_MSB:DST_LSB];
              entrada <= instr[IMM_MSB:IMM_LSB];
              wd      <= '0;
              state   <= ST_WAIT_RES;
            end else begin
              erro[1] <= 1'b1;
            end
          end
        end
        ST_WAIT_RES: begin
          // A result arriving on the expiry edge still wins over the abort.
          if (fimop) begin
            flag_ram <= 1'b1;
            state    <= ST_ACK;
          end else if (wd == WD_LAST) begin
            erro[0] <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        ST_ACK: begin
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          retired_q <= retired_q + 16'd1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state == ST_IDLE);
  assign retired     = retired_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_banco_registradores.sv
// Directed bench for banco_registradores: a driver issues instructions and
// plays the ALU, a monitor checks each issued operand set on flag_ram.
module tb_banco_registradores;
  import cpu_pkg::*;

  localparam int EW = 46;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [17:0] instr;
  logic [2:0]  opcode;
  logic [15:0] r2;
  logic [15:0] r3;
  logic [3:0]  D1;
  logic [6:0]  entrada;
  logic        fimop;
  logic [15:0] saida;
  logic        flag_ram;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] retired;
  logic [1:0]  erro;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic          prev_flag = 1'b0;

  banco_registradores #(.WIDTH(16), .TIMEOUT(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .r2          (r2),
    .r3          (r3),
    .D1          (D1),
    .entrada     (entrada),
    .fimop       (fimop),
    .saida       (saida),
    .flag_ram    (flag_ram),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .retired     (retired),
    .erro        (erro),
    .dbg_state   (dbg_state)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e, input string nm);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, e);
  endtask

  // Issue one instruction and answer as the ALU after lat WAIT_RES edges.
  task automatic run_op(input logic [17:0] ins, input int lat, input logic [15:0] res,
                        input logic [15:0] er2, input logic [15:0] er3, input bit hold);
    int n;
    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    saida       = res;
    exp_q.push_back({ins[17:15], er2, er3, ins[14:11], ins[6:0]});
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
    repeat (lat - 1) @(negedge clk);
    fimop       = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    fimop = 1'b0;
    n = 0;
    while (!instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("wb_latency", n, 2);
  endtask

  // Monitor: every flag_ram pulse must be single-cycle and carry the expected issue.
  always @(negedge clk) begin
    if (flag_ram) begin
      chk("flag_single", prev_flag, 1'b0);
      if (exp_q.size() == 0) chk("flag_unexpected", flag_ram, 1'b0);
      else chk("issue", {opcode, r2, r3, D1, entrada}, exp_q.pop_front());
    end
    prev_flag = flag_ram;
  end

  initial begin
    int n;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; fimop = 1'b0; saida = '0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_flag", flag_ram, 1'b0);
    chk("rst_retired", retired, 16'h0);
    chk("rst_erro", erro, 2'b00);
    chk("rst_alu_out", {opcode, r2, r3, D1, entrada}, '0);
    rd(4'd3, 16'h0, "rst_reg3");
    rd(4'd15, 16'h0, "rst_reg15");

    // Load 0xFFFF into R3 with a 2-cycle ALU.
    run_op({3'b000, 4'd3, 4'd0, 7'h7F}, 2, 16'hFFFF, 16'h0, 16'h0, 1'b0);
    rd(4'd3, 16'hFFFF, "load_reg3");
    chk("load_retired", retired, 16'd1);

    // Preload R1, R2, then add R4 = R1 + R2 at minimum spacing.
    run_op({3'b000, 4'd1, 4'd0, 7'h05}, 1, 16'h0005, 16'h0, 16'h0, 1'b0);
    run_op({3'b000, 4'd2, 4'd0, 7'h00}, 1, 16'hFFFE, 16'h0, 16'h0, 1'b0);
    run_op({3'b001, 4'd4, 4'd1, 4'd2, 3'b000}, 1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
    rd(4'd4, 16'h0003, "add_reg4");
    rd(4'd1, 16'h0005, "pre_reg1");
    chk("add_retired", retired, 16'd4);

    // R0 writes are discarded but still retire.
    run_op({3'b000, 4'd0, 4'd0, 7'h00}, 3, 16'h1234, 16'h0, 16'h0, 1'b0);
    rd(4'd0, 16'h0, "r0_zero");
    chk("r0_retired", retired, 16'd5);

    // instr_valid held through WAIT_RES: a single accept only.
    run_op({3'b010, 4'd5, 4'd1, 7'h03}, 5, 16'h0008, 16'h0005, 16'h0, 1'b1);
    rd(4'd5, 16'h0008, "bp_reg5");
    chk("bp_retired", retired, 16'd6);

    // Timeout: addi into R6 with no fimop.
    @(negedge clk);
    instr = {3'b010, 4'd6, 4'd1, 7'h01};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (!instr_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 255);
    chk("timeout_erro", erro, 2'b01);
    chk("timeout_retired", retired, 16'd6);
    rd(4'd6, 16'h0, "timeout_reg6");
    chk("hold_outputs", {opcode, r2, D1, entrada}, {3'b010, 16'h0005, 4'd6, 7'h01});

    // Illegal opcode: flagged, nothing issued.
    @(negedge clk);
    instr = {3'b111, 4'd7, 4'd1, 7'h00};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("illegal_erro", erro, 2'b11);
    chk("illegal_ready", instr_ready, 1'b1);
    chk("illegal_retired", retired, 16'd6);
    chk("illegal_no_issue", {opcode, D1}, {3'b010, 4'd6});

    // Retire counter wrap.
    @(negedge clk);
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    run_op({3'b000, 4'd7, 4'd0, 7'h00}, 2, 16'h00A5, 16'h0, 16'h0, 1'b0);
    chk("wrap_retired", retired, 16'h0000);
    rd(4'd7, 16'h00A5, "wrap_reg7");

    // Reset while in ACK.
    @(negedge clk);
    instr = {3'b001, 4'd8, 4'd3, 4'd4, 3'b000};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    fimop = 1'b1;
    @(posedge clk);
    #2;
    fimop = 1'b0;
    chk("ack_flag", flag_ram, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_flag", flag_ram, 1'b0);
    chk("rst_mid_state", dbg_state, ST_IDLE);
    chk("rst_mid_ready", instr_ready, 1'b1);
    chk("rst_mid_cnt", {retired, erro}, '0);
    chk("rst_mid_alu_out", {opcode, r2, r3, D1, entrada}, '0);
    for (int i = 0; i < 16; i++) rd(i[3:0], 16'h0, "rst_mid_reg");
    @(negedge clk);
    rst = 1'b0;

    // Normal operation after reset.
    run_op({3'b000, 4'd9, 4'd0, 7'h00}, 2, 16'h0042, 16'h0, 16'h0, 1'b0);
    rd(4'd9, 16'h0042, "post_reg9");
    chk("post_retired", retired, 16'd1);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
